// File: rtl/jtag_pkg.sv
// jtag_pkg: shared types for the JTAG scan controller.
//   tap_state_e  - IEEE 1149.1 TAP states, standard 4-bit encoding
//   cmd_type_e   - command opcodes accepted by jtag_scan_ctrl
//   ctrl_state_e - controller sequencing states
//   pre_last/pre_tms - TMS preamble tables (RESET uses the preamble as its whole body)
package jtag_pkg;

  localparam int MAX_LEN_DEF = 32;

  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    IR_SCAN = 2'd1,
    DR_SCAN = 2'd2,
    IDLE    = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    INIT, READY, PRE, SHIFT, POST, IDLE_CNT, DONE
  } ctrl_state_e;

  // Index of the final preamble step: IR 1,1,0,0 / DR 1,0,0 / RESET 1,1,1,1,1,0
  function automatic logic [2:0] pre_last(cmd_type_e t);
    case (t)
      IR_SCAN: return 3'd3;
      DR_SCAN: return 3'd2;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic pre_tms(cmd_type_e t, logic [2:0] step);
    case (t)
      IR_SCAN: return step < 3'd2;
      DR_SCAN: return step == 3'd0;
      default: return step < 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// jtag_tap_tracker: mirror of the target's 16-state TAP controller.
//   tck, trst_n - clock, async active-low reset (mirror -> TEST_LOGIC_RESET)
//   tms         - TMS value presented to the target this cycle
//   tap_state   - registered mirrored TAP state
module jtag_tap_tracker
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e tap_state
);

  tap_state_e nxt;

  always_comb begin
    nxt = tap_state;
    case (tap_state)
      TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   nxt = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        nxt = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          nxt = TEST_LOGIC_RESET;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n)
    if (!trst_n) tap_state <= TEST_LOGIC_RESET;
    else         tap_state <= nxt;

endmodule

// File: rtl/jtag_scan_ctrl.sv
// jtag_scan_ctrl: command-driven JTAG sequencer (RESET / IR_SCAN / DR_SCAN / IDLE).
//   tck, trst_n          - clock, async active-low reset
//   cmd_valid/cmd_ready  - command handshake; accepted only in READY (TAP in RTI)
//   cmd_type/len/data    - opcode, bit/cycle count, TDI payload (LSB first)
//   tms, tdi             - registered JTAG drives; tdo - target data out
//   rsp_valid            - one-cycle completion pulse
//   rsp_data, rsp_err    - captured TDO (LSB first) / illegal scan length, held until next rsp
//   busy                 - not in READY
//   tap_state            - mirrored target TAP state
module jtag_scan_ctrl
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  cmd_type_e          cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output tap_state_e         tap_state
);

  ctrl_state_e        state_q, state_d;
  cmd_type_e          typ_q, typ_d;
  logic [LEN_W-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [2:0]         step_q, step_d;
  logic [MAX_LEN-1:0] sr_q, sr_d, rsp_data_d;
  logic               rsp_err_d, tms_d, tdi_d;

  jtag_tap_tracker u_tap (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .tap_state (tap_state)
  );

  assign cmd_ready = (state_q == READY);
  assign busy      = ~cmd_ready;
  assign rsp_valid = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    typ_d      = typ_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    sr_d       = sr_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      // tms is already 0 from the first INIT cycle; TAP reaches RTI on this edge
      INIT: if (!tms) state_d = READY;
      READY: if (cmd_valid) begin
        typ_d  = cmd_type;
        len_d  = cmd_len;
        step_d = '0;
        // bits above len are cleared so the capture lands right-aligned with zero fill
        for (int j = 0; j < MAX_LEN; j++) sr_d[j] = cmd_data[j] & (j < int'(cmd_len));
        case (cmd_type)
          RESET: state_d = PRE;
          IDLE: begin
            if (cmd_len == '0) begin
              state_d    = DONE;
              rsp_data_d = '0;
              rsp_err_d  = 1'b0;
            end else begin
              state_d = IDLE_CNT;
              cnt_d   = cmd_len - LEN_W'(1);
            end
          end
          default: begin
            if (cmd_len == '0 || int'(cmd_len) > MAX_LEN) begin
              state_d    = DONE;
              rsp_data_d = '0;
              rsp_err_d  = 1'b1;
            end else begin
              state_d = PRE;
            end
          end
        endcase
      end
      PRE: begin
        if (step_q == pre_last(typ_q)) begin
          if (typ_q == RESET) begin
            state_d    = DONE;
            rsp_data_d = '0;
            rsp_err_d  = 1'b0;
          end else begin
            state_d = SHIFT;
            cnt_d   = len_q - LEN_W'(1);
          end
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      SHIFT: begin
        // TDI leaves from bit 0; TDO enters at bit len-1 so after len shifts
        // the first captured bit sits at bit 0
        sr_d = sr_q >> 1;
        for (int j = 0; j < MAX_LEN; j++)
          if (j == int'(len_q) - 1) sr_d[j] = tdo;
        if (cnt_q == '0) begin
          state_d = POST;
          step_d  = '0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      POST: begin
        if (step_q == 3'd1) begin
          state_d    = DONE;
          rsp_data_d = sr_q;
          rsp_err_d  = 1'b0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      IDLE_CNT: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DONE:    state_d = READY;
      default: state_d = INIT;
    endcase

    // tms/tdi are registered, so decode them from the state being entered
    tms_d = 1'b0;
    tdi_d = 1'b0;
    case (state_d)
      PRE:   tms_d = pre_tms(typ_d, step_d);
      SHIFT: begin
        tms_d = (cnt_d == '0);
        tdi_d = sr_d[0];
      end
      POST:  tms_d = (step_d == 3'd0);
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q  <= INIT;
      typ_q    <= RESET;
      len_q    <= '0;
      cnt_q    <= '0;
      step_q   <= '0;
      sr_q     <= '0;
      tms      <= 1'b1;
      tdi      <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q  <= state_d;
      typ_q    <= typ_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      sr_q     <= sr_d;
      tms      <= tms_d;
      tdi      <= tdi_d;
      rsp_data <= rsp_data_d;
      rsp_err  <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Directed bench for jtag_scan_ctrl with a small target TAP model
// (4-bit IR, IDCODE=0x1BA00477 at IR 0xE, 1-bit BYPASS otherwise).
module tb_jtag_scan_ctrl;
  import jtag_pkg::*;

  localparam logic [31:0] IDCODE = 32'h1BA0_0477;

  logic        tck = 1'b0;
  logic        trst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  cmd_type_e   cmd_type = IDLE;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ready, tms, tdi, tdo, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_data;
  tap_state_e  tap_state;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] tms_w, tdi_w;
  tap_state_e  tap_log [64];
  int          cyc, wt;

  jtag_scan_ctrl #(.MAX_LEN(32), .LEN_W(6)) dut (
    .tck       (tck),
    .trst_n    (trst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .tap_state (tap_state)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- target TAP model ----------------
  function automatic tap_state_e tap_next(tap_state_e s, logic m);
    case (s)
      TEST_LOGIC_RESET: return m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   return m ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       return m ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         return m ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         return m ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         return m ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         return m ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   return m ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       return m ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         return m ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         return m ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         return m ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         return m ? UPDATE_IR        : SHIFT_IR;
      default:          return m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
    endcase
  endfunction

  tap_state_e  m_st;
  logic [3:0]  m_ir, m_ir_sr;
  logic [31:0] m_dr;
  logic        m_byp;

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      m_st <= TEST_LOGIC_RESET; m_ir <= 4'hE; m_ir_sr <= '0; m_dr <= '0; m_byp <= 1'b0;
    end else begin
      m_st <= tap_next(m_st, tms);
      case (m_st)
        TEST_LOGIC_RESET: m_ir <= 4'hE;
        CAPTURE_IR:       m_ir_sr <= 4'b0001;
        SHIFT_IR:         m_ir_sr <= {tdi, m_ir_sr[3:1]};
        UPDATE_IR:        m_ir <= m_ir_sr;
        CAPTURE_DR:       begin m_dr <= IDCODE; m_byp <= 1'b0; end
        SHIFT_DR:         begin m_dr <= {tdi, m_dr[31:1]}; m_byp <= tdi; end
        default: ;
      endcase
    end
  end

  assign tdo = (m_st == SHIFT_IR) ? m_ir_sr[0] :
               (m_st == SHIFT_DR) ? ((m_ir == 4'hE) ? m_dr[0] : m_byp) : 1'b0;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for READY, issues one command, logs tms/tdi/tap per cycle until rsp_valid.
  // Returns at the negedge where rsp_valid is high; cycles = posedges from accept to DONE.
  task automatic run_cmd(input cmd_type_e t, input logic [5:0] len, input logic [31:0] data,
                         input bit noise, output int cycles, output int waits);
    waits = 0;
    while (!cmd_ready && waits < 50) begin @(negedge tck); waits++; end
    chk("cmd_ready_seen", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_type = t; cmd_len = len; cmd_data = data;
    @(negedge tck);
    cmd_valid = 1'b0; cmd_data = '0;
    chk("ready_drops_after_accept", cmd_ready, 0);
    cycles = 0; tms_w = '0; tdi_w = '0;
    while (!rsp_valid && cycles < 64) begin
      tms_w[cycles] = tms; tdi_w[cycles] = tdi; tap_log[cycles] = tap_state;
      if (noise) begin cmd_valid = (cycles >= 1 && cycles < 5); cmd_type = IDLE; end
      @(negedge tck);
      cycles++;
    end
    cmd_valid = 1'b0;
    chk("rsp_valid_seen", rsp_valid, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge tck);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_tap", tap_state, TEST_LOGIC_RESET);

    trst_n = 1'b1;
    @(negedge tck);
    chk("init_ready_low", cmd_ready, 0);
    chk("init_tms", tms, 0);
    @(negedge tck);
    chk("init_ready_2nd_edge", cmd_ready, 1);
    chk("init_tap_rti", tap_state, RUN_TEST_IDLE);
    chk("init_busy", busy, 0);

    // IDCODE read, with cmd_valid noise while busy
    run_cmd(DR_SCAN, 6'd32, 32'h0, 1'b1, cyc, wt);
    chk("idcode_cycles", cyc, 37);
    chk("idcode_data", rsp_data, IDCODE);
    chk("idcode_err", rsp_err, 0);
    chk("idcode_tms", tms_w, 64'h0000_000C_0000_0001);
    chk("idcode_tdi", tdi_w, 64'h0);
    @(negedge tck);
    chk("rsp_one_cycle", rsp_valid, 0);
    chk("ready_after_rsp", cmd_ready, 1);
    repeat (2) @(negedge tck);
    chk("noise_not_queued", cmd_ready, 1);
    chk("noise_tms_idle", tms, 0);

    // IR <- BYPASS
    run_cmd(IR_SCAN, 6'd4, 32'hF, 1'b0, cyc, wt);
    chk("ir_f_cycles", cyc, 10);
    chk("ir_f_tms", tms_w, 64'h183);
    chk("ir_f_tdi", tdi_w, 64'hF0);
    chk("ir_f_capture", rsp_data, 32'h1);
    chk("ir_f_model_ir", m_ir, 4'hF);

    // BYPASS: 1-bit delay, captured 0 first
    run_cmd(DR_SCAN, 6'd4, 32'hB, 1'b0, cyc, wt);
    chk("byp_cycles", cyc, 9);
    chk("byp_tms", tms_w, 64'hC1);
    chk("byp_tdi", tdi_w, 64'h58);
    chk("byp_data", rsp_data, 32'h6);

    // IR <- IDCODE
    run_cmd(IR_SCAN, 6'd4, 32'hE, 1'b0, cyc, wt);
    chk("ir_e_cycles", cyc, 10);
    chk("ir_e_tms", tms_w, 64'h183);
    chk("ir_e_tdi", tdi_w, 64'hE0);
    chk("ir_e_model_ir", m_ir, 4'hE);

    // single-bit DR scan; upper payload bits must not leak
    run_cmd(DR_SCAN, 6'd1, 32'hFFFF_FFFF, 1'b0, cyc, wt);
    chk("dr1_cycles", cyc, 6);
    chk("dr1_tms", tms_w, 64'h19);
    chk("dr1_tdi", tdi_w, 64'h08);
    chk("dr1_data", rsp_data, 32'h1);
    repeat (2) @(negedge tck);
    chk("rsp_data_held", rsp_data, 32'h1);
    chk("rsp_valid_low_held", rsp_valid, 0);

    // illegal lengths
    run_cmd(DR_SCAN, 6'd0, 32'hFFFF_FFFF, 1'b0, cyc, wt);
    chk("len0_cycles", cyc, 0);
    chk("len0_err", rsp_err, 1);
    chk("len0_data", rsp_data, 32'h0);
    chk("len0_tms", tms, 0);
    chk("len0_tap", tap_state, RUN_TEST_IDLE);
    @(negedge tck);
    chk("len0_tap_after", tap_state, RUN_TEST_IDLE);
    run_cmd(DR_SCAN, 6'd33, 32'hFFFF_FFFF, 1'b0, cyc, wt);
    chk("len33_cycles", cyc, 0);
    chk("len33_err", rsp_err, 1);
    chk("len33_data", rsp_data, 32'h0);
    chk("len33_tms", tms, 0);
    chk("len33_tap", tap_state, RUN_TEST_IDLE);

    // reset during shift bit 10 of a 32-bit scan
    wt = 0;
    while (!cmd_ready && wt < 50) begin @(negedge tck); wt++; end
    cmd_valid = 1'b1; cmd_type = DR_SCAN; cmd_len = 6'd32; cmd_data = 32'hFFFF_FFFF;
    @(negedge tck);
    cmd_valid = 1'b0;
    for (int k = 0; k < 13; k++) begin
      chk("abort_no_rsp_pre", rsp_valid, 0);
      @(negedge tck);
    end
    chk("abort_tap_shift", tap_state, SHIFT_DR);
    chk("abort_tdi_bit10", tdi, 1);
    #2 trst_n = 1'b0;
    #1;
    chk("abort_tms", tms, 1);
    chk("abort_tap", tap_state, TEST_LOGIC_RESET);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge tck);
      chk("abort_hold_tms", tms, 1);
      chk("abort_hold_rsp", rsp_valid, 0);
    end
    trst_n = 1'b1;
    wt = 0;
    while (!cmd_ready && wt < 50) begin
      @(negedge tck); wt++;
      chk("abort_no_rsp_post", rsp_valid, 0);
    end
    chk("abort_release_latency", wt, 2);

    run_cmd(IDLE, 6'd3, 32'h0, 1'b0, cyc, wt);
    chk("idle3_cycles", cyc, 3);
    chk("idle3_tms", tms_w, 64'h0);
    chk("idle3_err", rsp_err, 0);

    // RESET then IDLE back-to-back
    run_cmd(RESET, 6'd0, 32'h0, 1'b0, cyc, wt);
    chk("reset_cycles", cyc, 6);
    chk("reset_tms", tms_w, 64'h1F);
    chk("reset_reaches_tlr", tap_log[5], TEST_LOGIC_RESET);
    chk("reset_back_rti", tap_state, RUN_TEST_IDLE);
    run_cmd(IDLE, 6'd3, 32'h0, 1'b0, cyc, wt);
    chk("b2b_ready_gap", wt, 1);
    chk("b2b_idle_cycles", cyc, 3);
    chk("b2b_idle_tms", tms_w, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jtag_scan_ctrl.md
JTAG_SCAN_CTRL -- requirements
Module: jtag_scan_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 32, which is the maximum scan length in bits.
REQ-002 The block SHALL have parameter LEN_W, default 6, which is the width of cmd_len.
REQ-003 Port tck, input, 1 bit: the single clock; all state SHALL update on posedge tck.
REQ-004 Port trst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port cmd_valid, input, 1 bit: a command is present.
REQ-006 Port cmd_ready, output, 1 bit: the controller accepts a command this cycle.
REQ-007 Port cmd_type, input, 2 bits: jtag_pkg::cmd_type_e, with values RESET=0, IR_SCAN=1, DR_SCAN=2, IDLE=3.
REQ-008 Port cmd_len, input, LEN_W bits: shift bit count for scans, or cycle count for IDLE.
REQ-009 Port cmd_data, input, MAX_LEN bits: TDI payload, shifted LSB first.
REQ-010 Port tms, output, 1 bit: the registered TMS drive.
REQ-011 Port tdi, output, 1 bit: the registered TDI drive.
REQ-012 Port tdo, input, 1 bit: the target TDO.
REQ-013 Port rsp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-014 Port rsp_data, output, MAX_LEN bits: captured TDO, LSB first, with unshifted upper bits at 0.
REQ-015 Port rsp_err, output, 1 bit: the completed command was illegal.
REQ-016 Port busy, output, 1 bit: a command or the post-reset init is in progress.
REQ-017 Port tap_state, output, 4 bits: the mirrored target TAP state, of type jtag_pkg::tap_state_e.

Function
REQ-018 The block SHALL mirror the IEEE 1149.1 16-state TAP FSM, advancing the mirror each posedge on the tms value presented during that cycle.
REQ-019 The controller FSM SHALL have the states INIT, READY, PRE, SHIFT, POST, IDLE_CNT and DONE.
REQ-020 cmd_ready SHALL be 1 only in READY, and READY SHALL be entered only when tap_state is RUN_TEST_IDLE.
REQ-021 A command SHALL be accepted on a posedge with cmd_valid and cmd_ready both 1; cmd_type, cmd_len and cmd_data SHALL be latched at that edge.
REQ-022 INIT (after reset) SHALL drive tms=0 for one cycle (TEST_LOGIC_RESET to RUN_TEST_IDLE), then go to READY.
REQ-023 IR_SCAN SHALL drive the tms sequence 1,1,0,0, then cmd_len shift bits, then 1,0, for a total of len+6 cycles.
REQ-024 DR_SCAN SHALL drive the tms sequence 1,0,0, then cmd_len shift bits, then 1,0, for a total of len+5 cycles.
REQ-025 During shift, tms SHALL be 0 on every bit except the last, where tms=1 (SHIFT to EXIT1).
REQ-026 tdi SHALL be cmd_data[i] on shift bit i, and 0 in all other cycles.
REQ-027 rsp_data[i] SHALL be the tdo value sampled on the posedge at which tdi bit i is sampled.
REQ-028 RESET SHALL drive tms=1 for 5 cycles and then tms=0 for 1 cycle, for 6 cycles total.
REQ-029 IDLE SHALL drive tms=0 for cmd_len cycles; cmd_len=0 SHALL be legal and take 0 cycles.
REQ-030 A scan with cmd_len=0 or cmd_len>MAX_LEN SHALL drive no TMS activity and give rsp_err=1 and rsp_data=0.
REQ-031 rsp_valid SHALL be 1 for exactly one cycle (DONE), in the cycle after RUN_TEST_IDLE is re-entered.
REQ-032 rsp_data and rsp_err SHALL be held stable until the next rsp_valid.
REQ-033 READY SHALL follow DONE, so cmd_ready is 1 in the cycle after rsp_valid.
REQ-034 Back-to-back commands SHALL incur exactly one READY cycle between them.
REQ-035 busy SHALL be the inverse of (state==READY).
REQ-036 cmd_valid while not ready SHALL be ignored; no command SHALL be queued.
REQ-037 Illegal combinations of cmd_type and cmd_len SHALL never leave the mirror outside RUN_TEST_IDLE when in READY.

Reset
REQ-038 While trst_n=0, tms SHALL be 1, tdi 0, cmd_ready 0, rsp_valid 0, rsp_err 0, rsp_data 0, busy 1, tap_state TEST_LOGIC_RESET and the FSM in INIT.
REQ-039 Reset asserted mid-command SHALL abort immediately with no rsp_valid.
REQ-040 After reset deassertion, cmd_ready SHALL rise on the second posedge.

Structure
REQ-041 Package jtag_pkg SHALL hold tap_state_e (16 states, standard 4-bit encoding), cmd_type_e and the MAX_LEN default.
REQ-042 The block SHALL contain one sub-module, jtag_tap_tracker, with input tms and output the registered tap_state.
REQ-043 Shift data SHALL use one MAX_LEN-bit shift register and one LEN_W-bit down-counter.

Verification
REQ-044 Reset release followed by DR_SCAN with len=32, data=0, and the TAP model returning IDCODE 0x1BA00477 SHALL give rsp_data=0x1BA00477, rsp_err=0, and rsp_valid 37 cycles after accept.
REQ-045 IR_SCAN with len=4 and data=0xE SHALL give tms=1,1,0,0,0,0,0,1,1,0 and tdi=0,1,1,1 during shift; the model's IR SHALL be 0xE.
REQ-046 DR_SCAN with len=1 SHALL give a single shift cycle with tms=1, and rsp_data[0] equal to tdo.
REQ-047 DR_SCAN with len=0 and then len=33 SHALL each give rsp_err=1, no tms toggling, and tap_state RUN_TEST_IDLE throughout.
REQ-048 trst_n pulsed low at shift bit 10 of a 32-bit scan SHALL give no rsp_valid, and tms=1 while reset is held.
REQ-049 After that reset, the next IDLE command with len=3 SHALL complete normally.
REQ-050 RESET followed by IDLE len=3 issued back-to-back SHALL give a 6-cycle tms pattern 1,1,1,1,1,0, one READY cycle, then 3 cycles of tms=0.
